// File: rtl/mux2to1_arbiter.sv
// mux2to1_arbiter: packet-level round-robin arbiter sharing one output channel
// between two valid/ready requesters (A and B). It owns the mux select and
// holds a grant until the granted packet's last beat transfers, so packets never
// interleave. Data steering is combinational from the registered grant state,
// so no data latency is added.
//
// Optional feature: define MUX2TO1_ARB_STATS_EN to add per-requester packet
// counters (a_pkt_cnt, b_pkt_cnt). The counters wrap rather than saturate.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_valid/a_data/a_last      requester A beat
//   a_ready                    beat accepted from A
//   b_valid/b_data/b_last      requester B beat
//   b_ready                    beat accepted from B
//   f_valid/f_data/f_last      shared output channel beat
//   f_ready                    downstream accepts beat
//   sel                        registered mux select (0 = A, 1 = B)
//   busy                       a grant is active
//   a_pkt_cnt, b_pkt_cnt       packet-end counters (MUX2TO1_ARB_STATS_EN only)

module mux2to1_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             f_valid,
    output logic [WIDTH-1:0] f_data,
    output logic             f_last,
    input  logic             f_ready,
    output logic             sel,
    output logic             busy
`ifdef MUX2TO1_ARB_STATS_EN
    ,
    output logic [CNTW-1:0]  a_pkt_cnt,
    output logic [CNTW-1:0]  b_pkt_cnt
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_A = 2'd1;
    localparam logic [1:0] GNT_B = 2'd2;

    // Elaboration-time sanity check on the parameters.
    if (WIDTH == 0 || CNTW == 0) begin : g_param_chk
        $error("mux2to1_arbiter: WIDTH and CNTW must be at least 1");
    end

    logic [1:0] state_q, state_d;
    logic       prio_q, prio_d;
    logic       sel_q, sel_d;
    logic       a_end, b_end;

    // Round-robin pick: a lone requester wins, otherwise prio decides.
    function automatic logic [1:0] arb(input logic av, input logic bv, input logic pb);
        logic [1:0] r;
        r = IDLE;
        if (av && bv) begin
            r = pb ? GNT_B : GNT_A;
        end else if (av) begin
            r = GNT_A;
        end else if (bv) begin
            r = GNT_B;
        end
        return r;
    endfunction

    // Packet end: last beat of the granted requester transfers this cycle.
    always_comb begin
        a_end = (state_q == GNT_A) && a_valid && f_ready && a_last;
        b_end = (state_q == GNT_B) && b_valid && f_ready && b_last;
    end

    // Next state, priority pointer and select.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                state_d = arb(a_valid, b_valid, prio_q);
            end
            GNT_A: begin
                // Re-arbitrate on the same edge with prio pointing at B.
                if (a_end) begin
                    prio_d  = 1'b1;
                    state_d = arb(a_valid, b_valid, 1'b1);
                end
            end
            GNT_B: begin
                if (b_end) begin
                    prio_d  = 1'b0;
                    state_d = arb(a_valid, b_valid, 1'b0);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // sel follows every grant entry and holds through IDLE.
        if (state_d == GNT_A) begin
            sel_d = 1'b0;
        end else if (state_d == GNT_B) begin
            sel_d = 1'b1;
        end
    end

    // State, priority and select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
        end
    end

    // Output steering from the registered grant; the loser never sees ready.
    always_comb begin
        f_valid = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        f_data  = sel_q ? b_data : a_data;
        f_last  = sel_q ? b_last : a_last;
        case (state_q)
            GNT_A: begin
                f_valid = a_valid;
                a_ready = f_ready;
            end
            GNT_B: begin
                f_valid = b_valid;
                b_ready = f_ready;
            end
            default: begin
                f_valid = 1'b0;
            end
        endcase
    end

    assign sel  = sel_q;
    assign busy = (state_q != IDLE);

`ifdef MUX2TO1_ARB_STATS_EN
    logic [CNTW-1:0] a_cnt_q, a_cnt_d;
    logic [CNTW-1:0] b_cnt_q, b_cnt_d;

    // Packet counters, wrapping modulo 2**CNTW.
    always_comb begin
        a_cnt_d = a_cnt_q + CNTW'(a_end);
        b_cnt_d = b_cnt_q + CNTW'(b_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    assign a_pkt_cnt = a_cnt_q;
    assign b_pkt_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// Testbench for mux2to1_arbiter: per-requester source queues drive the inputs,
// expected output beats are queued as packets are loaded and compared as the
// output channel transfers them; grant/select timing is checked directly.

module tb_mux2to1_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNTW  = 4;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             a_valid, a_last, a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid, b_last, b_ready;
    logic [WIDTH-1:0] b_data;
    logic             f_valid, f_last, f_ready;
    logic [WIDTH-1:0] f_data;
    logic             sel, busy;
`ifdef MUX2TO1_ARB_STATS_EN
    logic [CNTW-1:0]  a_pkt_cnt, b_pkt_cnt;
`endif

    beat_t a_q[$];
    beat_t b_q[$];
    beat_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    mux2to1_arbiter #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_last  (a_last),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_last  (b_last),
        .b_ready (b_ready),
        .f_valid (f_valid),
        .f_data  (f_data),
        .f_last  (f_last),
        .f_ready (f_ready),
        .sel     (sel),
        .busy    (busy)
`ifdef MUX2TO1_ARB_STATS_EN
        ,
        .a_pkt_cnt (a_pkt_cnt),
        .b_pkt_cnt (b_pkt_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Present the head of each source queue.
    task automatic drive();
        if (a_q.size() != 0) begin
            a_valid = 1'b1;
            a_data  = a_q[0].data;
            a_last  = a_q[0].last;
        end else begin
            a_valid = 1'b0;
            a_data  = '0;
            a_last  = 1'b0;
        end
        if (b_q.size() != 0) begin
            b_valid = 1'b1;
            b_data  = b_q[0].data;
            b_last  = b_q[0].last;
        end else begin
            b_valid = 1'b0;
            b_data  = '0;
            b_last  = 1'b0;
        end
    endtask

    // Queue an n-beat packet on side (0 = A, 1 = B) and its expected output beats.
    task automatic add_pkt(input bit side, input logic [WIDTH-1:0] base, input int n);
        beat_t bt;
        for (int i = 0; i < n; i++) begin
            bt.data = base + WIDTH'(i);
            bt.last = (i == n - 1);
            if (side) b_q.push_back(bt);
            else      a_q.push_back(bt);
            exp_q.push_back(bt);
        end
    endtask

    // One clock: sample at negedge, score any output beat, advance sources.
    task automatic tick();
        bit    acc_a, acc_b;
        beat_t e;
        @(negedge clk);
        acc_a = a_valid && a_ready;
        acc_b = b_valid && b_ready;
        if (f_valid && f_ready) begin
            check("exp_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("f_data", 32'(f_data), 32'(e.data));
                check("f_last", 32'(f_last), 32'(e.last));
            end
        end
        @(posedge clk);
        #1;
        if (acc_a) void'(a_q.pop_front());
        if (acc_b) void'(b_q.pop_front());
        drive();
        #1;
    endtask

    task automatic do_reset();
        a_q.delete();
        b_q.delete();
        exp_q.delete();
        f_ready = 1'b1;
        drive();
        rst_n = 1'b0;
        #1;
        check("rst_f_valid", 32'(f_valid), 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_sel",     32'(sel),     32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n   = 1'b0;
        f_ready = 1'b1;
        drive();

        // 1: single 3-beat packet from A, one arbitration cycle first.
        do_reset();
        add_pkt(1'b0, 8'h11, 3);
        drive();
        #1;
        check("t1_arb_busy",   32'(busy),    32'd0);
        check("t1_arb_fvalid", 32'(f_valid), 32'd0);
        tick();
        check("t1_gnt_busy", 32'(busy),    32'd1);
        check("t1_gnt_sel",  32'(sel),     32'd0);
        check("t1_gnt_fv",   32'(f_valid), 32'd1);
        repeat (3) tick();
        check("t1_drain",  32'(exp_q.size()), 32'd0);
        check("t1_fv_end", 32'(f_valid),      32'd0);

        // 2: both requesters busy, 2-beat packets alternate with no bubble.
        do_reset();
        add_pkt(1'b0, 8'hA0, 2);
        add_pkt(1'b1, 8'hB0, 2);
        add_pkt(1'b0, 8'hA2, 2);
        add_pkt(1'b1, 8'hB2, 2);
        drive();
        tick();
        for (int p = 0; p < 4; p++) begin
            check("t2_sel", 32'(sel), 32'(p % 2));
            check("t2_fv",  32'(f_valid), 32'd1);
            tick();
            check("t2_fv_mid", 32'(f_valid), 32'd1);
            tick();
        end
        check("t2_drain", 32'(exp_q.size()), 32'd0);

        // 3: B stalled by f_ready mid-packet while A waits.
        do_reset();
        add_pkt(1'b1, 8'hC0, 3);
        drive();
        tick();
        add_pkt(1'b0, 8'hD0, 1);
        drive();
        tick();
        f_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t3_fdata",   32'(f_data),  32'hC1);
            check("t3_b_ready", 32'(b_ready), 32'd0);
            check("t3_a_ready", 32'(a_ready), 32'd0);
            check("t3_sel",     32'(sel),     32'd1);
            tick();
        end
        f_ready = 1'b1;
        tick();
        check("t3_still_b", 32'(sel), 32'd1);
        tick();
        check("t3_to_a", 32'(sel), 32'd0);
        tick();
        check("t3_drain", 32'(exp_q.size()), 32'd0);

        // 4: single-beat packets from A only, one beat per cycle.
        do_reset();
        for (int i = 0; i < 5; i++) add_pkt(1'b0, 8'hE0 + 8'(i), 1);
        drive();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t4_sel",  32'(sel),     32'd0);
            check("t4_fv",   32'(f_valid), 32'd1);
            tick();
        end
        check("t4_drain", 32'(exp_q.size()), 32'd0);

        // 5: asynchronous reset in the middle of a B packet.
        do_reset();
        add_pkt(1'b1, 8'hF0, 3);
        drive();
        tick();
        tick();
        check("t5_sel_pre", 32'(sel), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_fv",      32'(f_valid), 32'd0);
        check("t5_b_ready", 32'(b_ready), 32'd0);
        check("t5_busy",    32'(busy),    32'd0);
        check("t5_sel",     32'(sel),     32'd0);
        exp_q.delete();
        b_q.delete();
        drive();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        add_pkt(1'b1, 8'h50, 1);
        drive();
        #1;
        check("t5_arb_busy", 32'(busy), 32'd0);
        tick();
        check("t5_gnt_busy", 32'(busy), 32'd1);
        check("t5_gnt_sel",  32'(sel),  32'd1);
        tick();
        check("t5_drain", 32'(exp_q.size()), 32'd0);

`ifdef MUX2TO1_ARB_STATS_EN
        // 6: 17 A packets wrap a 4-bit counter to 1.
        do_reset();
        for (int i = 0; i < 17; i++) add_pkt(1'b0, 8'h30 + 8'(i), 1);
        drive();
        tick();
        repeat (17) tick();
        check("t6_drain", 32'(exp_q.size()), 32'd0);
        check("t6_a_cnt", 32'(a_pkt_cnt), 32'd1);
        check("t6_b_cnt", 32'(b_pkt_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
